// File: rtl/flight_sequencer.sv
// Game-level sequencer for the bird physics block: divides Clk into frame ticks,
// runs the IDLE/PLAY/DYING/DONE game FSM and issues one step or flap per frame.
module flight_sequencer #(
  parameter int TICK_DIV   = 833333,
  parameter int FLOOR_Y    = 40,
  parameter int CEIL_Y     = 470,
  parameter int DEATH_HOLD = 120
) (
  input  logic        Clk,
  input  logic        reset,
  input  logic        Start,
  input  logic        Ack,
  input  logic        BtnPress,
  input  logic        Collide,
  input  logic [9:0]  Bird_Y,
  output logic        PhysReset,
  output logic        PhysStep,
  output logic        Flap,
  output logic        q_Idle,
  output logic        q_Play,
  output logic        q_Dying,
  output logic        q_Done,
  output logic [15:0] FrameCnt
);

  localparam int TW = $clog2(TICK_DIV);
  localparam int DW = (DEATH_HOLD < 1) ? 1 : $clog2(DEATH_HOLD + 1);
  localparam logic signed [9:0] FLOOR_S = 10'(FLOOR_Y);
  localparam logic signed [9:0] CEIL_S  = 10'(CEIL_Y);

  typedef enum logic [1:0] {S_IDLE, S_PLAY, S_DYING, S_DONE} state_t;

  state_t          r_state;
  state_t          w_nextState;
  logic [TW-1:0]   r_tickCnt;
  logic            r_btnPrev;
  logic            r_flapPend;
  logic            r_physStep;
  logic            r_flap;
  logic [15:0]     r_frameCnt;
  logic [DW-1:0]   r_deathCnt;

  logic            w_tick;
  logic            w_edge;
  logic signed [9:0] w_birdY;
  logic            w_atFloor;
  logic            w_atCeil;
  logic            w_dieNow;
  logic            w_stepNext;
  logic            w_flapNext;
  logic            w_flapPendNext;
  logic [15:0]     w_frameNext;
  logic [DW-1:0]   w_deathNext;

  assign w_tick    = (r_tickCnt == TW'(TICK_DIV - 1));
  assign w_edge    = BtnPress & ~r_btnPrev;
  assign w_birdY   = $signed(Bird_Y);
  assign w_atFloor = (w_birdY <= FLOOR_S);
  assign w_atCeil  = (w_birdY >= CEIL_S);
  assign w_dieNow  = Collide | w_atFloor;

  always_ff @(posedge Clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_tickCnt  <= '0;
      r_btnPrev  <= 1'b0;
      r_flapPend <= 1'b0;
      r_physStep <= 1'b0;
      r_flap     <= 1'b0;
      r_frameCnt <= '0;
      r_deathCnt <= '0;
    end else begin
      r_state    <= w_nextState;
      r_tickCnt  <= w_tick ? '0 : r_tickCnt + 1'b1;
      r_btnPrev  <= BtnPress;
      r_flapPend <= w_flapPendNext;
      r_physStep <= w_stepNext;
      r_flap     <= w_flapNext;
      r_frameCnt <= w_frameNext;
      r_deathCnt <= w_deathNext;
    end
  end

  // A dying bird on a tick cycle always gets a plain step, never a flap.
  always_comb begin
    w_nextState    = r_state;
    w_stepNext     = 1'b0;
    w_flapNext     = 1'b0;
    w_flapPendNext = r_flapPend;
    w_frameNext    = r_frameCnt;
    w_deathNext    = r_deathCnt;
    case (r_state)
      S_IDLE: begin
        w_flapPendNext = 1'b0;
        if (Start) begin
          w_nextState = S_PLAY;
          w_frameNext = '0;
        end
      end
      S_PLAY: begin
        if (w_edge) w_flapPendNext = 1'b1;
        if (w_tick) begin
          w_flapPendNext = 1'b0;
          if (r_frameCnt != 16'hFFFF) w_frameNext = r_frameCnt + 16'd1;
          if (!w_dieNow && (r_flapPend || w_edge) && !w_atCeil) w_flapNext = 1'b1;
          else w_stepNext = 1'b1;
        end
        if (w_dieNow) begin
          w_nextState    = S_DYING;
          w_deathNext    = '0;
          w_flapPendNext = 1'b0;
        end
      end
      S_DYING: begin
        w_flapPendNext = 1'b0;
        if (w_tick) begin
          w_stepNext  = 1'b1;
          w_deathNext = r_deathCnt + 1'b1;
        end
        if (w_atFloor || (r_deathCnt == DW'(DEATH_HOLD))) w_nextState = S_DONE;
      end
      S_DONE: begin
        w_flapPendNext = 1'b0;
        if (Ack) w_nextState = S_IDLE;
      end
      default: w_nextState = S_IDLE;
    endcase
  end

  assign PhysReset = (r_state == S_IDLE);
  assign q_Idle    = (r_state == S_IDLE);
  assign q_Play    = (r_state == S_PLAY);
  assign q_Dying   = (r_state == S_DYING);
  assign q_Done    = (r_state == S_DONE);
  assign PhysStep  = r_physStep;
  assign Flap      = r_flap;
  assign FrameCnt  = r_frameCnt;

endmodule
